// File: rtl/picorv32_mem_dma.sv
// Word-copy DMA engine mastering a PicoRV32 native memory bus: read src, write dst, repeat len times.
// Optional MEMDMA_TIMEOUT_EN: abort a transfer that stalls for TIMEOUT_CYC cycles and flag err.
module picorv32_mem_dma #(
  parameter int LEN_W       = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             mem_valid,
  output logic             mem_instr,
  input  logic             mem_ready,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic [31:0]      mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

  state_t           state, state_nxt;
  logic [31:0]      src_q, dst_q;
  logic [LEN_W-1:0] cnt_q;
  logic             xfer;
  logic             timeout;

  assign xfer      = mem_valid && mem_ready;
  assign busy      = (state != IDLE);
  assign mem_instr = 1'b0;

`ifdef MEMDMA_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] timer_q;
  logic          err_q;

  // timer holds the number of stall cycles already seen before this one
  assign timeout = mem_valid && !mem_ready && (timer_q == TLIM);
  assign err     = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (mem_valid && !mem_ready && !timeout) timer_q <= timer_q + 1'b1;
      else                                     timer_q <= '0;
      if (state == IDLE && start) err_q <= 1'b0;
      else if (timeout)           err_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = (len == '0) ? FIN : RD;
      RD: begin
        if (timeout)   state_nxt = FIN;
        else if (xfer) state_nxt = WR;
      end
      WR: begin
        if (timeout)   state_nxt = FIN;
        else if (xfer) state_nxt = (cnt_q == LEN_W'(1)) ? FIN : RD;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus outputs are registered; a cycle with mem_valid low in RD/WR is the
  // mandatory idle gap, after which the next transfer is launched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q     <= '0;
      dst_q     <= '0;
      cnt_q     <= '0;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      done      <= 1'b0;
    end else begin
      done <= (state == FIN);
      unique case (state)
        IDLE: if (start) begin
          src_q <= {src_addr[31:2], 2'b00};
          dst_q <= {dst_addr[31:2], 2'b00};
          cnt_q <= len;
          if (len != '0) begin
            mem_valid <= 1'b1;
            mem_addr  <= {src_addr[31:2], 2'b00};
            mem_wstrb <= 4'h0;
          end
        end
        RD: begin
          if (timeout) mem_valid <= 1'b0;
          else if (xfer) begin
            mem_valid <= 1'b0;
            mem_wdata <= mem_rdata;
          end else if (!mem_valid) begin
            mem_valid <= 1'b1;
            mem_addr  <= src_q;
            mem_wstrb <= 4'h0;
          end
        end
        WR: begin
          if (timeout) begin
            mem_valid <= 1'b0;
            mem_wstrb <= 4'h0;
          end else if (xfer) begin
            mem_valid <= 1'b0;
            mem_wstrb <= 4'h0;
            src_q     <= src_q + 32'd4;
            dst_q     <= dst_q + 32'd4;
            cnt_q     <= cnt_q - 1'b1;
          end else if (!mem_valid) begin
            mem_valid <= 1'b1;
            mem_addr  <= dst_q;
            mem_wstrb <= 4'hF;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_picorv32_mem_dma.sv
// Randomized bench for picorv32_mem_dma: random-latency memory responder plus an
// expected-transfer queue built from a sequential word-copy model.
module tb_picorv32_mem_dma;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] src_addr, dst_addr;
  logic [15:0] len;
  logic        busy, done, err;
  logic        mem_valid, mem_instr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  always #5 clk = ~clk;

  picorv32_mem_dma #(.LEN_W(16), .TIMEOUT_CYC(255)) dut (
    .clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .len(len), .busy(busy), .done(done), .err(err), .mem_valid(mem_valid),
    .mem_instr(mem_instr), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  typedef struct {bit wr; logic [31:0] addr; logic [31:0] data;} xact_t;

  int          pass_cnt = 0, tot_cnt = 0;
  xact_t       exp_q[$];
  logic [31:0] bm[logic [31:0]];  // memory as seen through the bus
  logic [31:0] mm[logic [31:0]];  // memory as the model predicts it
  logic [31:0] rd_log[$];
  int          wr_cnt = 0, rd_cnt = 0, done_cnt = 0, vld_cnt = 0;
  bit          stall_all = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction
  function automatic logic [31:0] bm_rd(input logic [31:0] a);
    return bm.exists(a) ? bm[a] : dflt(a);
  endfunction
  function automatic logic [31:0] mm_rd(input logic [31:0] a);
    return mm.exists(a) ? mm[a] : dflt(a);
  endfunction

  // word copy in program order: each read sees every earlier write
  task automatic plan(input logic [31:0] s, input logic [31:0] d, input int n);
    logic [31:0] a, b, v;
    a = s & ~32'h3;
    b = d & ~32'h3;
    for (int i = 0; i < n; i++) begin
      v = mm_rd(a);
      exp_q.push_back('{wr: 1'b0, addr: a, data: v});
      exp_q.push_back('{wr: 1'b1, addr: b, data: v});
      mm[b] = v;
      a += 32'd4;
      b += 32'd4;
    end
  endtask

  // responder: random ready, occasionally asserts ready with no request pending
  initial begin mem_ready = 1'b0; mem_rdata = '0; end
  always @(posedge clk) begin
    #1;
    if (mem_valid) mem_ready = !stall_all && ($urandom_range(0, 2) != 0);
    else           mem_ready = ($urandom_range(0, 3) == 0);
    mem_rdata = bm_rd(mem_addr);
  end

  logic        p_stall = 1'b0, p_xfer = 1'b0;
  logic [31:0] p_addr, p_wdata;
  logic [3:0]  p_wstrb;
  xact_t       e;
  always @(posedge clk) begin
    if (reset) begin
      p_stall = 1'b0;
      p_xfer  = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (mem_valid) begin vld_cnt++; chk("instr", 32'(mem_instr), 0); end
      if (p_xfer) chk("gap_after_xfer", 32'(mem_valid), 0);
      if (p_stall && mem_valid) begin
        chk("hold_addr", mem_addr, p_addr);
        chk("hold_wdata", mem_wdata, p_wdata);
        chk("hold_wstrb", 32'(mem_wstrb), 32'(p_wstrb));
      end
      if (mem_valid && mem_ready) begin
        if (exp_q.size() == 0) chk("extra_xfer", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("xfer_addr", mem_addr, e.addr);
          chk("xfer_wstrb", 32'(mem_wstrb), e.wr ? 32'hF : 32'h0);
          if (e.wr) chk("xfer_wdata", mem_wdata, e.data);
        end
        if (mem_wstrb == 4'hF) begin bm[mem_addr] = mem_wdata; wr_cnt++; end
        else begin rd_cnt++; rd_log.push_back(mem_addr); end
      end
      p_stall = mem_valid && !mem_ready;
      p_xfer  = mem_valid && mem_ready;
      p_addr  = mem_addr;
      p_wdata = mem_wdata;
      p_wstrb = mem_wstrb;
    end
  end

  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int n, input bit intr);
    int d0;
    bit got;
    d0  = done_cnt;
    got = 1'b0;
    @(negedge clk);
    start = 1'b1; src_addr = s; dst_addr = d; len = 16'(n);
    plan(s, d, n);
    for (int k = 0; k < 3000 && !got; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) got = 1'b1;
      else if (intr && k == 3 && busy) begin
        start = 1'b1; src_addr = s ^ 32'h4000; dst_addr = d ^ 32'h8000; len = 16'(n + 3);
      end
    end
    chk("done_seen", 32'(got), 1);
    @(negedge clk);
    chk("done_pulses", 32'(done_cnt - d0), 1);
    chk("busy_after", 32'(busy), 0);
    chk("done_low", 32'(done), 0);
    chk("queue_empty", 32'(exp_q.size()), 0);
    chk("err_clear", 32'(err), 0);
    if (!got) exp_q.delete();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish, %0d/%0d checks passed", pass_cnt, tot_cnt);
    $fatal(1);
  end

  initial begin
    int          r0, w0, v0, got;
    logic [31:0] s, d;
    reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_valid", 32'(mem_valid), 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wstrb", 32'(mem_wstrb), 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_err", 32'(err), 0);
    reset = 1'b0;

    // directed 3-word copy
    bm[32'h100] = 32'h11111111; bm[32'h104] = 32'h22222222; bm[32'h108] = 32'h33333333;
    mm = bm;
    r0 = rd_cnt; w0 = wr_cnt;
    run_copy(32'h100, 32'h200, 3, 1'b0);
    chk("basic_reads", 32'(rd_cnt - r0), 3);
    chk("basic_writes", 32'(wr_cnt - w0), 3);
    chk("basic_w0", bm_rd(32'h200), 32'h11111111);
    chk("basic_w1", bm_rd(32'h204), 32'h22222222);
    chk("basic_w2", bm_rd(32'h208), 32'h33333333);

    // zero-length copy: FIN for one cycle, done on the next, no bus traffic
    v0 = vld_cnt;
    @(negedge clk); start = 1'b1; len = '0; src_addr = 32'h500; dst_addr = 32'h600;
    @(negedge clk); start = 1'b0;
    chk("len0_busy_c1", 32'(busy), 1);
    chk("len0_done_c1", 32'(done), 0);
    @(negedge clk);
    chk("len0_busy_c2", 32'(busy), 0);
    chk("len0_done_c2", 32'(done), 1);
    @(negedge clk);
    chk("len0_done_c3", 32'(done), 0);
    chk("len0_no_valid", 32'(vld_cnt - v0), 0);

    // start while busy must be ignored
    run_copy(32'h1000, 32'h2000, 5, 1'b1);
    repeat (20) @(negedge clk);
    chk("intrude_quiet", 32'(exp_q.size()), 0);

    // source address wraps past the top of memory
    rd_log.delete();
    run_copy(32'hFFFFFFFE, 32'h300, 2, 1'b0);
    chk("wrap_nreads", 32'(rd_log.size()), 2);
    if (rd_log.size() >= 2) begin
      chk("wrap_rd0", rd_log[0], 32'hFFFFFFFC);
      chk("wrap_rd1", rd_log[1], 32'h0);
    end

    // reset during a pending write
    @(negedge clk); start = 1'b1; src_addr = 32'h3000; dst_addr = 32'h3800; len = 16'd4;
    plan(32'h3000, 32'h3800, 4);
    got = 0;
    for (int k = 0; k < 500 && got == 0; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (mem_valid && mem_wstrb == 4'hF) got = 1;
    end
    chk("wr_pending_seen", 32'(got), 1);
    w0 = wr_cnt;
    reset = 1'b1;
    #1;
    chk("arst_valid", 32'(mem_valid), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_wstrb", 32'(mem_wstrb), 0);
    chk("arst_addr", mem_addr, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("arst_no_write", 32'(wr_cnt - w0), 0);
    mm = bm;
    run_copy(32'h3000, 32'h3800, 4, 1'b0);

    // random copies, some with overlapping source/destination
    for (int it = 0; it < 16; it++) begin
      s = 32'h10000 + (32'($urandom_range(0, 255)) << 2) + 32'($urandom_range(0, 3));
      d = (it % 4 == 0) ? s + 32'd4 : 32'h20000 + (32'($urandom_range(0, 255)) << 2) + 32'($urandom_range(0, 3));
      run_copy(s, d, $urandom_range(0, 6), it % 5 == 2);
    end

`ifdef MEMDMA_TIMEOUT_EN
    stall_all = 1'b1;
    v0 = vld_cnt;
    @(negedge clk); start = 1'b1; src_addr = 32'h4000; dst_addr = 32'h4800; len = 16'd2;
    got = 0;
    for (int k = 0; k < 600 && got == 0; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) got = 1;
    end
    chk("to_done", 32'(got), 1);
    chk("to_valid_cycles", 32'(vld_cnt - v0), 255);
    chk("to_err", 32'(err), 1);
    stall_all = 1'b0;
    exp_q.delete();
    mm = bm;
    run_copy(32'h4000, 32'h4800, 2, 1'b0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
